mem_req_initiator: RTL and testbench
====================================

// Module: mem_req_initiator
// PURPOSE
//  CPU-side initiator for the slow data-memory protocol (cs/we/addr/din -> dout/ack).
//  Accepts one load/store from the MEM stage, holds the memory bus stable until ack,
//  returns read data and stalls the pipeline meanwhile. Rejects stale acks and aborts
//  on timeout so a dead responder cannot hang the core.
// PARAMETERS
//  TIMEOUT_CYCLES  64  max cycles from bus issue to ack before abort (>=2)
//  CNT_W           7   timeout counter width, >= clog2(TIMEOUT_CYCLES+1)
// PORTS
//  clk         in   1   clock; all state on posedge
//  rst         in   1   reset, synchronous, active-high
//  req         in   1   MEM stage has a memory access this cycle
//  req_we      in   1   1=store, 0=load
//  req_addr    in   32  word address
//  req_wdata   in   32  store data
//  cpu_stall   out  1   hold pipeline (combinational)
//  rdata       out  32  load data, valid when rdata_valid
//  rdata_valid out  1   one-cycle completion pulse (load or store)
//  err         out  1   one-cycle timeout pulse
//  mem_cs      out  1   bus request, registered
//  mem_we      out  1   registered
//  mem_addr    out  32  registered
//  mem_din     out  32  registered
//  mem_dout    in   32  responder read data, sampled only with ack
//  mem_ack     in   1   responder ack
// BEHAVIOUR
//  Reset: state=IDLE, mem_cs/mem_we=0, mem_addr/mem_din=0, rdata=0,
//   rdata_valid=0, err=0, counter=0. Reset mid-transaction aborts: no pulse,
//   mem_cs low after the reset edge, captured data discarded.
//  States: IDLE, ARM, WAIT, DONE, ERR.
//  IDLE: req=1 at edge -> latch we/addr/wdata onto mem_*, mem_cs=1, cnt=0, -> ARM.
//  ARM: stale-ack guard. mem_ack=1 ignored; mem_ack=0 -> WAIT. cnt++ each cycle.
//  WAIT: mem_ack=1 -> rdata<=mem_dout (load) / unchanged (store), mem_cs<=0, -> DONE.
//   else cnt++.
//  Timeout: in ARM or WAIT, cnt==TIMEOUT_CYCLES-1 without qualifying ack -> mem_cs<=0,
//   rdata<=0, -> ERR. Ack and timeout in same cycle in WAIT: ack wins.
//  DONE: rdata_valid=1 for exactly this cycle; -> IDLE unconditionally.
//  ERR: err=1 for exactly this cycle; rdata_valid=0; -> IDLE.
//  cpu_stall = (state==IDLE & req) | state==ARM | state==WAIT. Low in DONE/ERR so the
//   pipeline advances exactly once per transaction.
//  mem_we/addr/din constant from IDLE exit until DONE/ERR entry (responder
//   requires stable address). mem_cs low for >=1 cycle between transactions
//   (DONE/ERR then IDLE), so back-to-back same-address accesses are distinct.
//  Minimum latency: req edge -> ARM -> WAIT -> DONE = 3 cycles with ack low in ARM
//   and ack on first WAIT cycle.
//  Counter saturates; never wraps. req sampled only in IDLE; req_* changes in other
//   states are ignored. rdata holds last value until next load completion, reset, or ERR.
// TESTING
//  1 Load 0x04, responder acks 8 cycles after cs, dout=0xDEADBEEF -> stall 10 cycles,
//    rdata_valid one cycle, rdata=0xDEADBEEF, mem_cs low next cycle.
//  2 Store addr 0x08 data 0x12345678 -> mem_we=1, mem_addr/din stable every cs cycle,
//    rdata_valid pulse on ack, rdata unchanged.
//  3 mem_ack held high from prior access for 3 cycles after new cs -> stays in ARM, no
//    completion until ack drops then re-rises.
//  4 Ack never asserted, TIMEOUT_CYCLES=64 -> err pulse 64 cycles after issue, rdata=0,
//    stall drops that cycle, mem_cs low.
//  5 rst asserted 4 cycles into WAIT -> next cycle all outputs reset, no rdata_valid/err;
//    new req afterwards completes normally.
//  6 Two back-to-back loads to 0x10 -> mem_cs low >=1 cycle between, two valid pulses.

Source files
------------

// File: rtl/mem_req_initiator.sv
// Purpose : CPU-side initiator for the slow data-memory bus (cs/we/addr/din -> dout/ack).
// Latency : 3 cycles minimum from req to the rdata_valid pulse; a dead responder aborts after TIMEOUT_CYCLES.
// Backpressure: cpu_stall holds the pipeline from req acceptance until the DONE/ERR cycle.
//
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   req/req_we/req_addr/req_wdata   access from the MEM stage (sampled only in IDLE)
//   cpu_stall           combinational pipeline hold
//   rdata/rdata_valid   load data and one-cycle completion pulse
//   err                 one-cycle timeout pulse
//   mem_cs/we/addr/din  registered bus request, held stable for the whole access
//   mem_dout/mem_ack    responder data and acknowledge
module mem_req_initiator #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        cpu_stall,
    output logic [31:0] rdata,
    output logic        rdata_valid,
    output logic        err,
    output logic        mem_cs,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    input  logic [31:0] mem_dout,
    input  logic        mem_ack
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ARM  = 3'd1,
        WAIT = 3'd2,
        DONE = 3'd3,
        ERR  = 3'd4
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             timeout;

    assign timeout = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        cpu_stall   = 1'b0;
        rdata_valid = 1'b0;
        err         = 1'b0;
        case (state)
            IDLE: begin
                cpu_stall = req;
                if (req) begin
                    state_nxt = ARM;
                end
            end
            ARM: begin
                // An ack still high from the previous access must drop before
                // a new one can be trusted; no ack qualifies here, so timeout wins.
                cpu_stall = 1'b1;
                if (timeout) begin
                    state_nxt = ERR;
                end else if (!mem_ack) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                // Ack beats a coincident timeout.
                cpu_stall = 1'b1;
                if (mem_ack) begin
                    state_nxt = DONE;
                end else if (timeout) begin
                    state_nxt = ERR;
                end
            end
            DONE: begin
                rdata_valid = 1'b1;
                state_nxt   = IDLE;
            end
            ERR: begin
                err       = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_cs   <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= 32'd0;
            mem_din  <= 32'd0;
            rdata    <= 32'd0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (req) begin
                        mem_cs   <= 1'b1;
                        mem_we   <= req_we;
                        mem_addr <= req_addr;
                        mem_din  <= req_wdata;
                        cnt      <= '0;
                    end
                end
                ARM, WAIT: begin
                    if (state_nxt == DONE) begin
                        mem_cs <= 1'b0;
                        if (!mem_we) begin
                            rdata <= mem_dout;
                        end
                    end else if (state_nxt == ERR) begin
                        mem_cs <= 1'b0;
                        rdata  <= 32'd0;
                    end else if (cnt != '1) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_req_initiator.sv
// Purpose : directed bench for mem_req_initiator with a per-access responder pattern.
// Latency : each access is driven from issue to completion pulse with a bounded wait.
// Backpressure: the bench counts cpu_stall cycles and compares against hand-computed totals.
module tb_mem_req_initiator;

    logic        clk;
    logic        rst;
    logic        req;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        cpu_stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        mem_cs;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_din;
    logic [31:0] mem_dout;
    logic        mem_ack;

    int total = 0;
    int bad   = 0;

    mem_req_initiator #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .cpu_stall  (cpu_stall),
        .rdata      (rdata),
        .rdata_valid(rdata_valid),
        .err        (err),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_din    (mem_din),
        .mem_dout   (mem_dout),
        .mem_ack    (mem_ack)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Issue one access from IDLE and drive the responder: ack is high for the
    // first 'pre' cycles after issue (stale ack) and again on cycle 'ack_at'
    // (-1 = never). Cycle index 0 is the first cycle with mem_cs high.
    task automatic do_access(input string tag, input logic we, input logic [31:0] addr,
                             input logic [31:0] wdata, input int pre, input int ack_at,
                             input logic [31:0] dout, input int exp_end, input logic exp_err,
                             input logic [31:0] exp_rdata, input int exp_stall);
        int stall_cnt;
        int hold_bad;
        int end_i;
        req       = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        #1;
        stall_cnt = cpu_stall ? 1 : 0;
        cyc();
        // Changes on req_* after acceptance must be ignored.
        req       = 1'b0;
        req_we    = ~we;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        hold_bad  = 0;
        end_i     = -1;
        for (int i = 0; i < 200; i++) begin
            mem_ack  = (i < pre) || (i == ack_at);
            mem_dout = (i == ack_at) ? dout : 32'hBAD0_BAD0;
            #1;
            if (rdata_valid || err) begin
                end_i = i;
                break;
            end
            if (cpu_stall) stall_cnt++;
            if (!mem_cs || mem_we !== we || mem_addr !== addr || mem_din !== wdata) hold_bad++;
            cyc();
        end
        chk({tag, ":end_cycle"}, end_i, exp_end);
        chk({tag, ":err"}, err, exp_err);
        chk({tag, ":valid"}, rdata_valid, !exp_err);
        chk({tag, ":rdata"}, rdata, exp_rdata);
        chk({tag, ":stall_cycles"}, stall_cnt, exp_stall);
        chk({tag, ":stall_at_end"}, cpu_stall, 1'b0);
        chk({tag, ":cs_at_end"}, mem_cs, 1'b0);
        chk({tag, ":bus_hold"}, hold_bad, 0);
        mem_ack  = 1'b0;
        mem_dout = 32'h0;
        cyc();
        chk({tag, ":pulse_once"}, rdata_valid | err, 1'b0);
        chk({tag, ":cs_gap"}, mem_cs, 1'b0);
    endtask

    initial begin
        rst       = 1'b1;
        req       = 1'b0;
        req_we    = 1'b0;
        req_addr  = 32'h0;
        req_wdata = 32'h0;
        mem_dout  = 32'h0;
        mem_ack   = 1'b0;
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst:mem_cs", mem_cs, 1'b0);
        chk("rst:mem_we", mem_we, 1'b0);
        chk("rst:mem_addr", mem_addr, 32'h0);
        chk("rst:mem_din", mem_din, 32'h0);
        chk("rst:rdata", rdata, 32'h0);
        chk("rst:valid", rdata_valid, 1'b0);
        chk("rst:err", err, 1'b0);
        chk("rst:stall", cpu_stall, 1'b0);
        cyc();

        // Load, ack 8 cycles after cs: 1 issue + 1 ARM + 8 WAIT = 10 stall cycles.
        do_access("t1_load", 1'b0, 32'h4, 32'h0, 0, 8, 32'hDEADBEEF, 9, 1'b0, 32'hDEADBEEF, 10);

        // Store: rdata keeps the previous load value.
        do_access("t2_store", 1'b1, 32'h8, 32'h12345678, 0, 3, 32'h5555AAAA, 4, 1'b0, 32'hDEADBEEF, 5);

        // Stale ack high for 3 cycles, drops, re-rises on cycle 5 -> DONE on cycle 6.
        do_access("t3_stale", 1'b0, 32'hC, 32'h0, 3, 5, 32'hCAFEF00D, 6, 1'b0, 32'hCAFEF00D, 7);

        // Reset four cycles into WAIT.
        req      = 1'b1;
        req_we   = 1'b0;
        req_addr = 32'h20;
        cyc();
        req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            mem_ack = 1'b0;
            cyc();
        end
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chk("t5:mem_cs", mem_cs, 1'b0);
        chk("t5:mem_addr", mem_addr, 32'h0);
        chk("t5:rdata", rdata, 32'h0);
        chk("t5:valid", rdata_valid, 1'b0);
        chk("t5:err", err, 1'b0);
        chk("t5:stall", cpu_stall, 1'b0);
        begin
            int pulses;
            pulses = 0;
            for (int i = 0; i < 4; i++) begin
                cyc();
                if (rdata_valid || err || mem_cs) pulses++;
            end
            chk("t5:quiet_after_rst", pulses, 0);
        end
        do_access("t5_after", 1'b0, 32'h24, 32'h0, 0, 2, 32'h0BADF00D, 3, 1'b0, 32'h0BADF00D, 4);

        // No ack: err 64 cycles after issue, rdata cleared.
        do_access("t4_timeout", 1'b0, 32'h30, 32'h0, 0, -1, 32'h0, 64, 1'b1, 32'h0, 65);

        // Back-to-back loads to the same address, minimum latency.
        do_access("t6_a", 1'b0, 32'h10, 32'h0, 0, 1, 32'h11111111, 2, 1'b0, 32'h11111111, 3);
        do_access("t6_b", 1'b0, 32'h10, 32'h0, 0, 1, 32'h22222222, 2, 1'b0, 32'h22222222, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
